// File: rtl/aurora_tx_frame_arb_pkg.sv
// Shared definitions for the Aurora TX frame arbiter: state encoding, LocalLink
// active-low levels and the default frame-length limit.
package aurora_tx_frame_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int   MAX_WORDS_DEF = 98;
  localparam int   CNT_W         = 7;
  localparam logic LL_ON         = 1'b0;
  localparam logic LL_OFF        = 1'b1;

  typedef struct packed {
    logic [15:0] d;
    logic        sof_n;
    logic        eof_n;
    logic        src_rdy_n;
  } ll_word_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aurora_tx_frame_arb_rr_pick.sv
// Combinational round-robin selector: first requester after 'last', wrapping,
// so 'last' itself has the lowest priority.
module aurora_tx_frame_arb_rr_pick
  import aurora_tx_frame_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    int c;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    c     = 0;
    for (int off = 1; off <= N; off++) begin
      c = (int'(last) + off) % N;
      if (!valid && req[c]) begin
        valid  = 1'b1;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/aurora_tx_frame_arb.sv
// Round-robin arbiter multiplexing NUM_SRC LocalLink frame sources onto one
// Aurora TX user interface, truncating frames longer than MAX_WORDS.
module aurora_tx_frame_arb
  import aurora_tx_frame_arb_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic                   USER_CLK,
  input  logic                   RESET,
  input  logic                   CHANNEL_UP,
  input  logic [16*NUM_SRC-1:0]  SRC_D,
  input  logic [NUM_SRC-1:0]     SRC_SOF_N,
  input  logic [NUM_SRC-1:0]     SRC_EOF_N,
  input  logic [NUM_SRC-1:0]     SRC_SRC_RDY_N,
  output logic [NUM_SRC-1:0]     SRC_DST_RDY_N,
  output logic [15:0]            TX_D,
  output logic                   TX_REM,
  output logic                   TX_SOF_N,
  output logic                   TX_EOF_N,
  output logic                   TX_SRC_RDY_N,
  input  logic                   TX_DST_RDY_N,
  output logic [NUM_SRC-1:0]     GRANT,
  output logic [NUM_SRC-1:0]     OVERSIZE_ERR
);

  localparam int IW = idx_w(NUM_SRC);

  logic                      reset_c;
  logic [NUM_SRC-1:0][15:0]  src_d;
  state_t                    state, state_nxt;
  logic [IW-1:0]             g_idx, g_nxt, last, last_nxt;
  logic [NUM_SRC-1:0]        grant_nxt, ovf_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic                      at_limit;
  logic                      src_acc;
  logic [NUM_SRC-1:0]        eligible, pick_gnt;
  logic [IW-1:0]             pick_idx;
  logic                      pick_valid;
  ll_word_t                  tx;

  assign reset_c = RESET | ~CHANNEL_UP;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_d[i]    = SRC_D[16*i +: 16];
    assign eligible[i] = (SRC_SRC_RDY_N[i] == LL_ON) && (SRC_SOF_N[i] == LL_ON);
  end

  aurora_tx_frame_arb_rr_pick #(.N(NUM_SRC), .IW(IW)) u_rr_pick (
    .req   (eligible),
    .last  (last),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign at_limit = (cnt == CNT_W'(MAX_WORDS - 1));
  // Handshake taken from source-side signals to avoid looping through TX_SRC_RDY_N.
  assign src_acc  = (SRC_SRC_RDY_N[g_idx] == LL_ON) && (TX_DST_RDY_N == LL_ON);

  always_ff @(posedge USER_CLK) begin
    if (reset_c) begin
      state        <= ST_IDLE;
      GRANT        <= '0;
      g_idx        <= '0;
      last         <= IW'(NUM_SRC - 1);
      cnt          <= '0;
      OVERSIZE_ERR <= '0;
    end else begin
      state        <= state_nxt;
      GRANT        <= grant_nxt;
      g_idx        <= g_nxt;
      last         <= last_nxt;
      cnt          <= cnt_nxt;
      OVERSIZE_ERR <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = GRANT;
    g_nxt         = g_idx;
    last_nxt      = last;
    cnt_nxt       = cnt;
    ovf_nxt       = OVERSIZE_ERR;
    tx            = '{d: 16'h0, sof_n: LL_OFF, eof_n: LL_OFF, src_rdy_n: LL_OFF};
    SRC_DST_RDY_N = '1;

    case (state)
      ST_IDLE: begin
        // Mid-frame leftovers (no SOF) are flushed so they cannot block arbitration.
        for (int i = 0; i < NUM_SRC; i++)
          if (SRC_SRC_RDY_N[i] == LL_ON && SRC_SOF_N[i] == LL_OFF)
            SRC_DST_RDY_N[i] = LL_ON;
        if (pick_valid) begin
          state_nxt = ST_XFER;
          grant_nxt = pick_gnt;
          g_nxt     = pick_idx;
          cnt_nxt   = '0;
        end
      end

      ST_XFER: begin
        tx.d                 = src_d[g_idx];
        tx.sof_n             = SRC_SOF_N[g_idx];
        tx.src_rdy_n         = SRC_SRC_RDY_N[g_idx];
        tx.eof_n             = at_limit ? LL_ON : SRC_EOF_N[g_idx];
        SRC_DST_RDY_N[g_idx] = TX_DST_RDY_N;
        if (src_acc) begin
          if (SRC_EOF_N[g_idx] == LL_ON) begin
            state_nxt = ST_IDLE;
            grant_nxt = '0;
            last_nxt  = g_idx;
          end else if (at_limit) begin
            state_nxt      = ST_DRAIN;
            ovf_nxt[g_idx] = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        SRC_DST_RDY_N[g_idx] = LL_ON;
        if (SRC_SRC_RDY_N[g_idx] == LL_ON && SRC_EOF_N[g_idx] == LL_ON) begin
          state_nxt = ST_IDLE;
          grant_nxt = '0;
          last_nxt  = g_idx;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  assign TX_D         = tx.d;
  assign TX_SOF_N     = tx.sof_n;
  assign TX_EOF_N     = tx.eof_n;
  assign TX_SRC_RDY_N = tx.src_rdy_n;
  assign TX_REM       = 1'b1;

endmodule

// File: tb/tb_aurora_tx_frame_arb.sv
// Bench for aurora_tx_frame_arb: queue-based LocalLink sources, frame-level
// scoreboard of the expected (truncated) TX frames and sticky error flags.
module tb_aurora_tx_frame_arb;
  import aurora_tx_frame_arb_pkg::*;

  localparam int NS = 4;
  localparam int MW = 98;

  logic              USER_CLK = 1'b0;
  logic              RESET, CHANNEL_UP;
  logic [16*NS-1:0]  SRC_D;
  logic [NS-1:0]     SRC_SOF_N, SRC_EOF_N, SRC_SRC_RDY_N, SRC_DST_RDY_N;
  logic [15:0]       TX_D;
  logic              TX_REM, TX_SOF_N, TX_EOF_N, TX_SRC_RDY_N, TX_DST_RDY_N;
  logic [NS-1:0]     GRANT, OVERSIZE_ERR;

  aurora_tx_frame_arb #(.NUM_SRC(NS), .MAX_WORDS(MW)) dut (
    .USER_CLK(USER_CLK), .RESET(RESET), .CHANNEL_UP(CHANNEL_UP),
    .SRC_D(SRC_D), .SRC_SOF_N(SRC_SOF_N), .SRC_EOF_N(SRC_EOF_N),
    .SRC_SRC_RDY_N(SRC_SRC_RDY_N), .SRC_DST_RDY_N(SRC_DST_RDY_N),
    .TX_D(TX_D), .TX_REM(TX_REM), .TX_SOF_N(TX_SOF_N), .TX_EOF_N(TX_EOF_N),
    .TX_SRC_RDY_N(TX_SRC_RDY_N), .TX_DST_RDY_N(TX_DST_RDY_N),
    .GRANT(GRANT), .OVERSIZE_ERR(OVERSIZE_ERR)
  );

  always #5 USER_CLK = ~USER_CLK;

  typedef struct packed { logic [15:0] d; logic sof; logic eof; } sw_t;

  sw_t         src_q  [NS][$];
  logic [15:0] exp_w  [NS][$];
  int          exp_len[NS][$];
  int          grant_log[$];
  logic [NS-1:0] exp_ovf;
  int  checks = 0, failures = 0, cyc = 0;
  bit  gaps = 0, tog = 0;
  int  rdy_mode = 0;
  bit  in_frame = 0;
  int  cur_src, cur_cnt, cur_len, last_eof_cyc = 0, last_gap = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected TX frame: first MW words, EOF forced on the last kept word.
  task automatic add_frame(input int s, input int len);
    for (int k = 0; k < len; k++) begin
      sw_t w;
      w.d = 16'($urandom); w.sof = (k == 0); w.eof = (k == len - 1);
      src_q[s].push_back(w);
      if (k < MW) exp_w[s].push_back(w.d);
    end
    exp_len[s].push_back(len < MW ? len : MW);
    if (len > MW) exp_ovf[s] = 1'b1;
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      if (src_q[i].size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
        SRC_SRC_RDY_N[i]  = 1'b0;
        SRC_D[16*i +: 16] = src_q[i][0].d;
        SRC_SOF_N[i]      = ~src_q[i][0].sof;
        SRC_EOF_N[i]      = ~src_q[i][0].eof;
      end else begin
        SRC_SRC_RDY_N[i]  = 1'b1;
        SRC_D[16*i +: 16] = 16'($urandom);
        SRC_SOF_N[i]      = 1'($urandom);
        SRC_EOF_N[i]      = 1'($urandom);
      end
    end
    case (rdy_mode)
      0:       TX_DST_RDY_N = 1'b0;
      1:       begin tog = ~tog; TX_DST_RDY_N = tog; end
      default: TX_DST_RDY_N = 1'($urandom_range(1));
    endcase
  endtask

  task automatic tx_word();
    int g = -1;
    for (int i = 0; i < NS; i++) if (GRANT[i]) g = i;
    chk("tx_word_has_grant", 32'(g >= 0), 1);
    if (g < 0) return;
    if (!in_frame) begin
      chk("tx_sof_first", TX_SOF_N, 0);
      chk("frame_expected", 32'(exp_len[g].size() > 0), 1);
      if (exp_len[g].size() == 0) return;
      in_frame = 1; cur_src = g; cur_cnt = 0; cur_len = exp_len[g].pop_front();
      grant_log.push_back(g);
      last_gap = cyc - last_eof_cyc;
    end else begin
      chk("tx_sof_mid", TX_SOF_N, 1);
      chk("grant_stable", g, cur_src);
    end
    chk("tx_data_avail", 32'(exp_w[g].size() > 0), 1);
    if (exp_w[g].size() > 0) chk("tx_data", TX_D, exp_w[g].pop_front());
    cur_cnt++;
    chk("tx_eof", TX_EOF_N, (cur_cnt == cur_len) ? 0 : 1);
    if (cur_cnt == cur_len) begin in_frame = 0; last_eof_cyc = cyc; end
  endtask

  task automatic sample();
    cyc++;
    chk("grant_onehot0", 32'($onehot0(GRANT)), 1);
    if (TX_SRC_RDY_N === 1'b0 && TX_DST_RDY_N === 1'b0) tx_word();
    for (int i = 0; i < NS; i++)
      if (SRC_SRC_RDY_N[i] == 1'b0 && SRC_DST_RDY_N[i] === 1'b0 && src_q[i].size() > 0)
        void'(src_q[i].pop_front());
  endtask

  task automatic step();
    @(negedge USER_CLK); sample();
    @(posedge USER_CLK); #1; drive();
  endtask

  function automatic bit busy();
    for (int i = 0; i < NS; i++) if (src_q[i].size() > 0) return 1;
    return in_frame;
  endfunction

  task automatic run(input string tag, input int budget);
    int n = 0;
    while (busy() && n < budget) begin step(); n++; end
    chk({tag, "_completes"}, 32'(n < budget), 1);
    repeat (3) step();
  endtask

  task automatic do_reset();
    RESET = 1'b1; repeat (3) step();
    RESET = 1'b0; in_frame = 0; exp_ovf = '0; grant_log.delete();
    step();
  endtask

  task automatic chk_order(input string tag, input int exp_o[$]);
    chk({tag, "_count"}, grant_log.size(), exp_o.size());
    for (int k = 0; k < exp_o.size() && k < grant_log.size(); k++)
      chk({tag, "_src"}, grant_log[k], exp_o[k]);
  endtask

  initial begin
    int n;
    RESET = 1'b1; CHANNEL_UP = 1'b1; exp_ovf = '0;
    @(posedge USER_CLK); #1; drive();
    do_reset();

    // Reset / idle state
    @(negedge USER_CLK);
    chk("rst_grant", GRANT, 0);
    chk("rst_tx_src_rdy", TX_SRC_RDY_N, 1);
    chk("rst_tx_sof", TX_SOF_N, 1);
    chk("rst_tx_eof", TX_EOF_N, 1);
    chk("rst_tx_d", TX_D, 0);
    chk("rst_tx_rem", TX_REM, 1);
    chk("rst_ovf", OVERSIZE_ERR, 0);
    chk("rst_dst_rdy", SRC_DST_RDY_N, 4'hF);
    @(posedge USER_CLK); #1; drive();

    // Two simultaneous max-length frames: source 0 first, one idle bubble, then 2
    add_frame(0, 98); add_frame(2, 98);
    run("two_src", 1000);
    chk_order("two_src_order", '{0, 2});
    chk("two_src_bubble", last_gap, 2);
    chk("two_src_no_ovf", OVERSIZE_ERR, 0);

    // Oversize 120-word frame truncated, tail drained, then a normal frame
    grant_log.delete();
    add_frame(1, 120); add_frame(1, 5);
    run("oversize", 1000);
    chk_order("oversize_order", '{1, 1});
    chk("oversize_flag", OVERSIZE_ERR, exp_ovf);
    chk("oversize_idle", GRANT, 0);

    // Back-pressure toggling every other cycle; error flag must stay sticky
    rdy_mode = 1;
    add_frame(3, 98);
    run("toggle_rdy", 1000);
    chk("sticky_ovf", OVERSIZE_ERR, exp_ovf);
    rdy_mode = 0;

    // Channel drop at word 40 abandons the frame
    add_frame(1, 98);
    n = 0;
    while (!(in_frame && cur_cnt >= 40) && n < 1000) begin step(); n++; end
    chk("drop_reach_word40", 32'(n < 1000), 1);
    CHANNEL_UP = 1'b0;
    step();
    @(negedge USER_CLK);
    chk("drop_grant", GRANT, 0);
    chk("drop_tx_src_rdy", TX_SRC_RDY_N, 1);
    chk("drop_ovf_cleared", OVERSIZE_ERR, 0);
    for (int k = cur_cnt; k < cur_len; k++) void'(exp_w[cur_src].pop_front());
    in_frame = 0; exp_ovf = '0; grant_log.delete();
    sample();
    @(posedge USER_CLK); #1; drive();
    repeat (2) step();
    CHANNEL_UP = 1'b1;
    add_frame(2, 10);
    run("after_drop", 1000);
    chk_order("after_drop_order", '{2});

    // All sources requesting: rotation 0,1,2,3,0 including a one-word frame
    do_reset();
    add_frame(0, 4); add_frame(0, 3); add_frame(1, 5); add_frame(2, 2); add_frame(3, 1);
    run("rr_all", 500);
    chk_order("rr_order", '{0, 1, 2, 3, 0});

    // Randomised traffic: gaps, random back-pressure, lengths around the limit
    do_reset();
    gaps = 1; rdy_mode = 2;
    for (int f = 0; f < 14; f++) begin
      int s, len;
      s = $urandom_range(NS - 1);
      case ($urandom_range(4))
        0: len = 1;
        1: len = MW - 1;
        2: len = MW;
        3: len = MW + 1;
        default: len = $urandom_range(110, 1);
      endcase
      add_frame(s, len);
    end
    run("random", 20000);
    chk("random_ovf", OVERSIZE_ERR, exp_ovf);
    chk("random_idle", GRANT, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aurora_tx_frame_arb.md
AURORA_TX_FRAME_ARB -- requirements
Module: aurora_tx_frame_arb

Interface
REQ-001 Parameter NUM_SRC, default 4, number of frame sources sharing the Aurora TX user interface.
REQ-002 Parameter MAX_WORDS, default 98, maximum 16-bit words per frame.
REQ-003 USER_CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 CHANNEL_UP  input  1  Aurora channel ready; low acts as reset.
REQ-006 SRC_D  input  16*NUM_SRC  per-source data; source i occupies bits [16i+15:16i].
REQ-007 SRC_SOF_N, SRC_EOF_N, SRC_SRC_RDY_N  input  NUM_SRC each  per-source LocalLink framing, active-low.
REQ-008 SRC_DST_RDY_N  output  NUM_SRC  per-source accept, active-low.
REQ-009 TX_D  output  16  data to Aurora TX.
REQ-010 TX_REM  output  1  constant 1.
REQ-011 TX_SOF_N, TX_EOF_N, TX_SRC_RDY_N  output  1 each  framing to Aurora TX, active-low.
REQ-012 TX_DST_RDY_N  input  1  Aurora TX accept, active-low.
REQ-013 GRANT  output  NUM_SRC  one-hot registered grant; all-zero when idle.
REQ-014 OVERSIZE_ERR  output  NUM_SRC  sticky per-source error flags.

Function
REQ-015 Internal reset reset_c = RESET or not CHANNEL_UP.
REQ-016 States: IDLE, XFER, DRAIN; 2-bit encoding.
REQ-017 A word is accepted on the TX side when TX_SRC_RDY_N=0 and TX_DST_RDY_N=0 in the same cycle.
REQ-018 IDLE: eligible source = SRC_SRC_RDY_N[i]=0 and SRC_SOF_N[i]=0; round-robin search starts at (last granted index + 1) mod NUM_SRC.
REQ-019 IDLE with an eligible source: GRANT set to that source and go to XFER on the next edge; one-cycle arbitration bubble, no word passes in IDLE.
REQ-020 IDLE: all TX_*_N outputs 1, TX_D = 0.
REQ-021 IDLE: a source with SRC_SRC_RDY_N=0 and SRC_SOF_N=1 gets SRC_DST_RDY_N=0; its word is discarded.
REQ-022 IDLE: all other SRC_DST_RDY_N bits are 1.
REQ-023 XFER: combinational pass-through of the granted source: TX_D, TX_SOF_N, TX_SRC_RDY_N from the source; SRC_DST_RDY_N[g] = TX_DST_RDY_N; all other SRC_DST_RDY_N bits 1.
REQ-024 XFER: a 7-bit word counter clears on entry and increments per accepted word.
REQ-025 XFER: accepted word with SRC_EOF_N=0 -> IDLE, GRANT cleared, last-granted index updated to g.
REQ-026 XFER: when the counter equals MAX_WORDS-1 and the source EOF is high, force TX_EOF_N=0 on that word.
REQ-027 On acceptance of that forced-EOF word, set OVERSIZE_ERR[g] and go to DRAIN.
REQ-028 XFER: TX_EOF_N otherwise follows the source.
REQ-029 DRAIN: TX_SRC_RDY_N=1; SRC_DST_RDY_N[g]=0; source words are discarded until a word with SRC_EOF_N=0 and SRC_SRC_RDY_N=0, then -> IDLE.
REQ-030 A source EOF coinciding with the forced EOF counts as a normal end: -> IDLE, no error.
REQ-031 A one-word frame (SOF and EOF on the same word) is legal.
REQ-032 TX_DST_RDY_N high stalls the counter and state; outputs hold.
REQ-033 The grant does not change mid-frame, whatever the other sources request.

Reset
REQ-034 reset_c forces IDLE, GRANT=0, last-granted index = NUM_SRC-1 (so source 0 wins first), word counter 0, OVERSIZE_ERR=0.
REQ-035 reset_c mid-frame abandons the frame; the next frame on TX starts with SOF.

Structure
REQ-036 Shared package holds the state encoding, the MAX_WORDS default and the LocalLink active-low level constants.
REQ-037 Sub-module rr_pick: combinational round-robin priority selector (request vector + last index -> one-hot grant + valid).

Verification
REQ-038 Sources 0 and 2 both issue 98-word frames at the same time after reset -> source 0 frame, 1 idle cycle, then source 2 frame; SOF/EOF appear once each per frame.
REQ-039 Source 1 issues a 120-word frame -> TX EOF on word 98, OVERSIZE_ERR[1]=1, words 99-120 consumed with no TX_SRC_RDY_N low, return to IDLE.
REQ-040 TX_DST_RDY_N toggles every other cycle during a 98-word frame -> 98 words, in order, no duplicates.
REQ-041 CHANNEL_UP drops at word 40 -> next cycle GRANT=0 and TX_SRC_RDY_N=1; after CHANNEL_UP returns, the next frame starts cleanly.
REQ-042 All 4 sources continuously request -> grant order 0,1,2,3,0; a single-word frame from source 3 passes correctly.
